// File: rtl/sublist_writer.sv
// sublist_writer: fills the inactive bank of the sublist line RAM with glyph columns and swaps banks on rd_sync.
// Optional control-code filtering is enabled by defining SUBLIST_CTRL_FILTER_EN.
module sublist_writer #(
    parameter int CHAR_W = 8,
    parameter int CHAR_H = 16,
    parameter int CPSBLN = 32,
    parameter int CODE_W = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  char_valid,
    input  logic [CODE_W-1:0]                     char_code,
    input  logic                                  char_eol,
    output logic                                  char_ready,
    output logic [CODE_W+$clog2(CHAR_W)-1:0]      font_addr,
    input  logic [CHAR_H-1:0]                     font_col,
    output logic                                  wr_en,
    output logic                                  wr_bank,
    output logic [$clog2(CPSBLN*CHAR_W)-1:0]      wr_addr,
    output logic [CHAR_H-1:0]                     wr_data,
    output logic                                  rd_bank,
    input  logic                                  rd_sync,
    output logic                                  line_done
);
    localparam int LW = $clog2(CHAR_W);
    localparam int CW = $clog2(CHAR_W + 1);
    localparam int SW = $clog2(CPSBLN + 1);
    localparam int AW = $clog2(CPSBLN * CHAR_W);
    localparam int FW = CODE_W + LW;

    typedef enum logic [1:0] {IDLE, FETCH, PAD, WAIT_SYNC} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     col, col_n;
    logic [SW-1:0]     slot, slot_n;
    logic [CODE_W-1:0] code, code_n, in_code;
    logic              eol, eol_n, blank, blank_n, in_eol, in_blank;
    logic              rd_bank_n, char_ready_n, wr_en_n, line_done_n;
    logic [AW-1:0]     wr_addr_n;
    logic [CHAR_H-1:0] wr_data_n;
    logic [FW-1:0]     font_addr_n;

`ifdef SUBLIST_CTRL_FILTER_EN
    assign in_blank = (char_code < CODE_W'('h20)) || (char_code == CODE_W'('h7F));
    assign in_code  = in_blank ? CODE_W'('h20) : char_code;
    assign in_eol   = char_eol || (char_code == CODE_W'('h0A));
`else
    assign in_blank = 1'b0;
    assign in_code  = char_code;
    assign in_eol   = char_eol;
`endif

    assign wr_bank = ~rd_bank;

    // Next state and next registered outputs; every output is a flop so writes track state by one cycle
    always_comb begin
        state_n      = state;
        col_n        = col;
        slot_n       = slot;
        code_n       = code;
        eol_n        = eol;
        blank_n      = blank;
        rd_bank_n    = rd_bank;
        char_ready_n = 1'b0;
        wr_en_n      = 1'b0;
        wr_addr_n    = wr_addr;
        wr_data_n    = wr_data;
        font_addr_n  = font_addr;
        line_done_n  = 1'b0;
        case (state)
            IDLE: begin
                char_ready_n = 1'b1;
                if (char_valid) begin
                    state_n      = FETCH;
                    col_n        = '0;
                    code_n       = in_code;
                    eol_n        = in_eol;
                    blank_n      = in_blank;
                    font_addr_n  = {in_code, {LW{1'b0}}};
                    char_ready_n = 1'b0;
                end
            end
            FETCH: begin
                if (col != CW'(CHAR_W)) begin
                    col_n       = col + CW'(1);
                    font_addr_n = {code, col_n[LW-1:0]};
                    wr_en_n     = 1'b1;
                    wr_addr_n   = AW'(slot * CHAR_W) + AW'(col);
                    wr_data_n   = blank ? '0 : font_col;
                    if (col == CW'(CHAR_W - 1))
                        slot_n = slot + SW'(1);
                end else if (slot == SW'(CPSBLN)) begin
                    state_n = WAIT_SYNC;
                end else if (eol) begin
                    state_n   = PAD;
                    wr_en_n   = 1'b1;
                    wr_addr_n = AW'(slot * CHAR_W);
                    wr_data_n = '0;
                end else begin
                    state_n      = IDLE;
                    char_ready_n = 1'b1;
                end
            end
            PAD: begin
                if (wr_addr == AW'(CPSBLN * CHAR_W - 1)) begin
                    state_n = WAIT_SYNC;
                end else begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = wr_addr + AW'(1);
                    wr_data_n = '0;
                end
            end
            WAIT_SYNC: begin
                if (rd_sync) begin
                    state_n      = IDLE;
                    rd_bank_n    = ~rd_bank;
                    line_done_n  = 1'b1;
                    slot_n       = '0;
                    char_ready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset discarding any partial line
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            col        <= '0;
            slot       <= '0;
            code       <= '0;
            eol        <= 1'b0;
            blank      <= 1'b0;
            rd_bank    <= 1'b0;
            char_ready <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            font_addr  <= '0;
            line_done  <= 1'b0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            slot       <= slot_n;
            code       <= code_n;
            eol        <= eol_n;
            blank      <= blank_n;
            rd_bank    <= rd_bank_n;
            char_ready <= char_ready_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            font_addr  <= font_addr_n;
            line_done  <= line_done_n;
        end
    end
endmodule

// File: tb/tb_sublist_writer.sv
// tb_sublist_writer: directed checks of glyph fetch, padding, bank handover and reset for sublist_writer.
module tb_sublist_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        char_valid = 1'b0;
    logic [6:0]  char_code = '0;
    logic        char_eol = 1'b0;
    logic        char_ready;
    logic [9:0]  font_addr;
    logic [15:0] font_col;
    logic        wr_en, wr_bank, rd_bank, line_done;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_sync = 1'b0;

    int errors = 0;
    int checks = 0;
    int nwr = 0;
    int nld = 0;
    int last_addr = -1;
    logic [15:0] mem [2][256];

    sublist_writer dut (
        .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
        .char_eol(char_eol), .char_ready(char_ready), .font_addr(font_addr),
        .font_col(font_col), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_bank(rd_bank), .rd_sync(rd_sync), .line_done(line_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [6:0] c, input int k);
        logic [7:0] d;
        d = {1'b0, c} - 8'h41;
        return 16'h00FF + 16'(k) + {d, 8'h00};
    endfunction

    assign font_col = rom(font_addr[9:3], int'(font_addr[2:0]));

    // Line RAM model and event counters
    always @(negedge clk) begin
        if (rst && wr_en) begin
            mem[wr_bank][wr_addr] = wr_data;
            nwr = nwr + 1;
            last_addr = int'(wr_addr);
        end
        if (rst && line_done)
            nld = nld + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        char_valid = 1'b0;
        rd_sync = 1'b0;
        tick;
        tick;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++)
                mem[b][a] = 16'hDEAD;
        nwr = 0;
        nld = 0;
        last_addr = -1;
        rst = 1'b1;
    endtask

    task automatic send(input logic [6:0] c, input logic e);
        int n;
        n = 0;
        while (!char_ready && n < 400) begin
            tick;
            n++;
        end
        if (!char_ready)
            chk("ready_timeout", 32'(char_ready), 1);
        char_valid = 1'b1;
        char_code = c;
        char_eol = e;
        tick;
        char_valid = 1'b0;
        char_eol = 1'b0;
    endtask

    task automatic pulse_sync;
        rd_sync = 1'b1;
        tick;
        rd_sync = 1'b0;
    endtask

    initial begin
        int bad;
        // Reset values
        do_reset;
        chk("rst_ready", 32'(char_ready), 1);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_font_addr", 32'(font_addr), 0);
        chk("rst_line_done", 32'(line_done), 0);
        chk("rst_rd_bank", 32'(rd_bank), 0);
        chk("rst_wr_bank", 32'(wr_bank), 1);

        // Single 'A': cycle-exact fetch and write timing
        send(7'h41, 1'b0);
        chk("a_font_addr0", 32'(font_addr), 32'h208);
        bad = 0;
        for (int c = 1; c <= 9; c++) begin
            if (char_ready !== 1'b0) bad++;
            if (c == 1 && wr_en !== 1'b0) bad++;
            if (c >= 2 && (wr_en !== 1'b1 || int'(wr_addr) != c - 2 || wr_data !== 16'h00FF + 16'(c - 2))) bad++;
            if (c < 9) tick;
        end
        chk("a_fetch_cycles", 32'(bad), 0);
        tick;
        chk("a_ready_back", 32'(char_ready), 1);
        chk("a_wr_en_off", 32'(wr_en), 0);
        chk("a_nwr", 32'(nwr), 8);
        chk("a_last", 32'(wr_data), 32'h0106);
        send(7'h42, 1'b0);
        repeat (10) tick;
        chk("b_slot1_addr", 32'(last_addr), 15);
        chk("b_slot1_data", 32'(mem[1][8]), 32'(rom(7'h42, 0)));

        // Full line of 32 chars, then handover
        do_reset;
        for (int i = 0; i < 32; i++)
            send(7'h41 + 7'(i % 26), 1'b0);
        repeat (12) tick;
        chk("full_nwr", 32'(nwr), 256);
        chk("full_last_addr", 32'(last_addr), 255);
        chk("full_first", 32'(mem[1][0]), 32'(rom(7'h41, 0)));
        chk("full_end", 32'(mem[1][255]), 32'(rom(7'h41 + 7'(31 % 26), 7)));
        chk("full_wait_ready", 32'(char_ready), 0);
        chk("full_wait_wr_en", 32'(wr_en), 0);
        chk("full_rd_bank", 32'(rd_bank), 0);
        pulse_sync;
        chk("swap_line_done", 32'(line_done), 1);
        chk("swap_rd_bank", 32'(rd_bank), 1);
        chk("swap_wr_bank", 32'(wr_bank), 0);
        chk("swap_ready", 32'(char_ready), 1);
        tick;
        chk("swap_pulse_once", 32'(line_done), 0);
        chk("swap_nld", 32'(nld), 1);
        send(7'h43, 1'b0);
        repeat (10) tick;
        chk("swap_slot0_addr", 32'(last_addr), 7);
        chk("swap_new_bank", 32'(mem[0][0]), 32'(rom(7'h43, 0)));

        // Early eol on 3rd char: pad remainder with zeros
        do_reset;
        send(7'h44, 1'b0);
        send(7'h45, 1'b0);
        send(7'h46, 1'b1);
        repeat (300) tick;
        chk("eol_nwr", 32'(nwr), 256);
        chk("eol_glyph_end", 32'(mem[1][23]), 32'(rom(7'h46, 7)));
        bad = 0;
        for (int a = 24; a < 256; a++)
            if (mem[1][a] !== 16'h0) bad++;
        chk("eol_pad_zero", 32'(bad), 0);
        chk("eol_last_addr", 32'(last_addr), 255);
        chk("eol_wait_ready", 32'(char_ready), 0);
        chk("eol_no_swap", 32'(rd_bank), 0);

        // rd_sync outside WAIT_SYNC and on the final write is ignored
        do_reset;
        for (int i = 0; i < 4; i++)
            send(7'h41 + 7'(i), 1'b0);
        send(7'h45, 1'b0);
        tick;
        tick;
        pulse_sync;
        tick;
        chk("early_sync_ld", 32'(line_done), 0);
        chk("early_sync_bank", 32'(rd_bank), 0);
        for (int i = 5; i < 31; i++)
            send(7'h41 + 7'(i % 26), 1'b0);
        send(7'h50, 1'b0);
        repeat (8) tick;
        chk("final_wr_en", 32'(wr_en), 1);
        chk("final_wr_addr", 32'(wr_addr), 255);
        pulse_sync;
        chk("final_sync_ld", 32'(line_done), 0);
        chk("final_sync_bank", 32'(rd_bank), 0);
        repeat (3) tick;
        chk("final_sync_nld", 32'(nld), 0);
        pulse_sync;
        chk("late_sync_ld", 32'(line_done), 1);
        chk("late_sync_bank", 32'(rd_bank), 1);

        // Reset during FETCH column 4
        send(7'h41, 1'b0);
        repeat (4) tick;
        chk("midrst_writing", 32'(wr_en), 1);
        rst = 1'b0;
        tick;
        chk("midrst_wr_en", 32'(wr_en), 0);
        chk("midrst_ready", 32'(char_ready), 1);
        chk("midrst_rd_bank", 32'(rd_bank), 0);
        chk("midrst_wr_addr", 32'(wr_addr), 0);
        rst = 1'b1;

        // Control code 0x0A
        do_reset;
        send(7'h42, 1'b0);
        send(7'h0A, 1'b0);
        tick;
        tick;
`ifdef SUBLIST_CTRL_FILTER_EN
        chk("lf_font_addr", 32'(font_addr), 32'h102);
        repeat (300) tick;
        chk("lf_nwr", 32'(nwr), 256);
        chk("lf_col0", 32'(mem[1][8]), 0);
        chk("lf_col7", 32'(mem[1][15]), 0);
        chk("lf_pad_end", 32'(mem[1][255]), 0);
        chk("lf_ready", 32'(char_ready), 0);
`else
        chk("lf_font_addr", 32'(font_addr), 32'h052);
        repeat (300) tick;
        chk("lf_nwr", 32'(nwr), 16);
        chk("lf_col0", 32'(mem[1][8]), 32'(rom(7'h0A, 0)));
        chk("lf_col7", 32'(mem[1][15]), 32'(rom(7'h0A, 7)));
        chk("lf_no_pad", 32'(mem[1][16]), 32'hDEAD);
        chk("lf_ready", 32'(char_ready), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
